ibex_apmu_counter_bank: RTL and testbench
=========================================

Name: ibex_apmu_counter_bank

Overview:
Memory-mapped bank of event counters that serves the core's counter interface. It consumes the req/we/addr/wdata transactions driven by the core-side counter unit and returns rdata/rvalid/err one cycle later. Each counter increments on a selectable hardware event line. The block flags wrap-around in a sticky overflow register and can raise an interrupt.

Parameters:
NUM_COUNTERS, 4, number of 32-bit counters (legal range 1..16)
NUM_EVENTS, 8, width of event_i (legal range 2..32)
BASE_ADDR, 32'h1A10_0000, byte base address of the bank (4 KiB aligned)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
counter_req_i  in  1  request from core counter unit
counter_we_i  in  1  1 = write, 0 = read
counter_addr_i  in  32  byte address
counter_wdata_i  in  32  write data
counter_rdata_o  out  32  read data, valid with counter_rvalid_o
counter_rvalid_o  out  1  response strobe, one cycle after req
counter_err_o  out  1  error response, qualified by counter_rvalid_o
event_i  in  NUM_EVENTS  per-cycle event pulses, level-sampled every clock
overflow_irq_o  out  1  OR of (OVF & IRQ_EN)

Behaviour:
- Reset state (asynchronous, rst_ni low): all counters 0, EVSEL 0, CTRL 0, OVF 0, IRQ_EN 0. Outputs rvalid=0, err=0, rdata=0, irq=0.
- Register map (offset from BASE_ADDR):
  - 0x000 CTRL: bit0 EN (global count enable); bit1 CLR (write-1 clears all counters, self-clearing, reads 0).
  - 0x004 OVF: bit i = counter i wrapped, sticky; write-1-to-clear.
  - 0x008 IRQ_EN: bit i enables the interrupt for counter i.
  - 0x040+4*i CNT[i]: read/write.
  - 0x080+4*i EVSEL[i]: low clog2(NUM_EVENTS) bits are stored; upper bits read 0.
  - Bits beyond NUM_COUNTERS in OVF and IRQ_EN read 0 and ignore writes.
- Decode: a request is erroneous in any of these cases, and err=1 is returned with rvalid:
  - address outside [BASE_ADDR, BASE_ADDR+0xFFF];
  - addr[1:0] != 0;
  - counter index >= NUM_COUNTERS;
  - unmapped offset.
  - An erroneous write has no side effect. An erroneous read returns rdata=0.
- Handshake:
  - Request accepted every cycle; no backpressure.
  - rvalid asserts exactly one cycle after each accepted req, for reads and writes. Back-to-back requests give back-to-back rvalid.
  - rdata is 0 on writes and when rvalid=0.
  - Read data is the register value at the request cycle, i.e. before that cycle's increment.
- Counting, per counter i, each cycle:
  - inc_i = EN & event_i[EVSEL[i]]. An EVSEL value >= NUM_EVENTS selects no event (inc_i=0).
  - Priority, highest first: CLR write > CNT[i] write > increment.
  - CNT[i] = 0xFFFF_FFFF with inc_i=1 wraps to 0 and sets OVF[i] the next cycle.
- Simultaneous events:
  - OVF W1C and a same-cycle wrap on bit i: the set wins (OVF[i]=1).
  - CTRL write of EN=0 takes effect from the next cycle. An increment in the write cycle still uses the old EN.
  - CLR does not clear OVF or EVSEL.
- overflow_irq_o = |(OVF & IRQ_EN). It is combinational from registers, so it asserts the cycle after the wrapping edge.
- Reset mid-transaction: a pending rvalid is dropped (rvalid=0 after reset), and no response is issued for the request killed by reset.

Test Plan:
- Reset and idle: hold rst_ni low 3 cycles, release -> every CNT/CTRL/OVF reads 0x0 with err=0, and each rvalid arrives exactly 1 cycle after its req.
- Basic count: EVSEL[1]=3, CTRL=0x1, pulse event_i[3] for 10 cycles (other events toggling) -> CNT[1]=10, CNT[0]=CNT[2]=CNT[3] counted only their EVSEL[*]=0 source.
- Wrap and IRQ: CNT[2]=0xFFFF_FFFE, IRQ_EN=0x4, EN=1, event held high 2 cycles -> CNT[2]=0x0, OVF=0x4, irq=1. Write OVF=0x4 -> irq=0.
- Priority: write CNT[0]=0x55 in the same cycle its event fires -> CNT[0]=0x55 (not 0x56). Write CTRL=0x3 while events fire -> all CNT=0, EN=1.
- Errors: read BASE_ADDR+0x050 with NUM_COUNTERS=4, read BASE_ADDR+0x002, write BASE_ADDR+0x1000 -> each returns rvalid=1, err=1, rdata=0, and no register changes.
- Reset mid-op: assert rst_ni the cycle after a read req -> no rvalid is produced, and all registers are 0 after release.

Source files
------------

// File: rtl/ibex_apmu_counter_bank_if.sv
// Request/response bus between the core-side counter unit and the event counter bank.
// The master issues req/we/addr/wdata; the bank answers with rdata/rvalid/err one cycle later.
interface ibex_apmu_counter_bank_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, rvalid, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, rvalid, err
  );
endinterface

// File: rtl/ibex_apmu_counter_bank.sv
// Memory-mapped bank of 32-bit event counters with per-counter event select,
// sticky wrap flags and a maskable overflow interrupt.
module ibex_apmu_counter_bank #(
  parameter int unsigned NUM_COUNTERS = 4,
  parameter int unsigned NUM_EVENTS   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1A10_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  ibex_apmu_counter_bank_if.slave    counter,
  input  logic [NUM_EVENTS-1:0]      event_i,
  output logic                       overflow_irq_o
);

  localparam int unsigned EvselW = $clog2(NUM_EVENTS);

  logic                                en_q, en_d;
  logic [NUM_COUNTERS-1:0]             ovf_q, ovf_d;
  logic [NUM_COUNTERS-1:0]             irq_en_q, irq_en_d;
  logic [NUM_COUNTERS-1:0][31:0]       cnt_q, cnt_d;
  logic [NUM_COUNTERS-1:0][EvselW-1:0] evsel_q, evsel_d;
  logic [NUM_COUNTERS-1:0]             inc, wrap;

  logic        rvalid_q, err_q;
  logic [31:0] rdata_q, rdata_d;

  // Address decode
  logic [11:0] offset;
  logic [3:0]  idx;
  logic        in_bank, aligned, idx_ok;
  logic        sel_ctrl, sel_ovf, sel_irq, sel_cnt, sel_evsel;
  logic        dec_ok, wr, rd, clr;

  assign offset    = counter.addr[11:0];
  assign idx       = offset[5:2];
  assign in_bank   = counter.addr[31:12] == BASE_ADDR[31:12];
  assign aligned   = counter.addr[1:0] == 2'b00;
  assign idx_ok    = 32'(idx) < NUM_COUNTERS;
  assign sel_ctrl  = offset == 12'h000;
  assign sel_ovf   = offset == 12'h004;
  assign sel_irq   = offset == 12'h008;
  assign sel_cnt   = (offset[11:6] == 6'h01) && idx_ok;
  assign sel_evsel = (offset[11:6] == 6'h02) && idx_ok;
  assign dec_ok    = in_bank && aligned && (sel_ctrl || sel_ovf || sel_irq || sel_cnt || sel_evsel);
  assign wr        = counter.req && counter.we && dec_ok;
  assign rd        = counter.req && !counter.we && dec_ok;
  assign clr       = wr && sel_ctrl && counter.wdata[1];

  // Read data reflects register state before this cycle's update
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (sel_ctrl) rdata_d = {31'b0, en_q};
      if (sel_ovf)  rdata_d = 32'(ovf_q);
      if (sel_irq)  rdata_d = 32'(irq_en_q);
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (idx == 4'(i)) begin
          if (sel_cnt)   rdata_d = cnt_q[i];
          if (sel_evsel) rdata_d = 32'(evsel_q[i]);
        end
      end
    end
  end

  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    evsel_d  = evsel_q;
    cnt_d    = cnt_q;
    inc      = '0;
    wrap     = '0;
    if (wr && sel_ctrl) en_d = counter.wdata[0];
    if (wr && sel_irq)  irq_en_d = counter.wdata[NUM_COUNTERS-1:0];
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      // Out-of-range selects match no event line and never count
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if (evsel_q[i] == EvselW'(e)) inc[i] = en_q && event_i[e];
      end
      if (wr && sel_evsel && (idx == 4'(i))) evsel_d[i] = counter.wdata[EvselW-1:0];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (wr && sel_cnt && (idx == 4'(i))) begin
        cnt_d[i] = counter.wdata;
      end else if (inc[i]) begin
        cnt_d[i] = cnt_q[i] + 32'd1;
        wrap[i]  = &cnt_q[i];
      end
    end
    // A same-cycle wrap overrides the W1C
    ovf_d = ovf_q;
    if (wr && sel_ovf) ovf_d = ovf_q & ~counter.wdata[NUM_COUNTERS-1:0];
    ovf_d = ovf_d | wrap;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      ovf_q    <= '0;
      irq_en_q <= '0;
      cnt_q    <= '0;
      evsel_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      cnt_q    <= cnt_d;
      evsel_q  <= evsel_d;
      rvalid_q <= counter.req;
      err_q    <= counter.req && !dec_ok;
      rdata_q  <= rdata_d;
    end
  end

  assign counter.rvalid = rvalid_q;
  assign counter.err    = err_q;
  assign counter.rdata  = rdata_q;
  assign overflow_irq_o = |(ovf_q & irq_en_q);

endmodule

// File: tb/tb_ibex_apmu_counter_bank.sv
// Scoreboard bench for the event counter bank: the driver queues expected responses,
// a negedge monitor pops and compares them whenever rvalid is seen.
module tb_ibex_apmu_counter_bank;
  localparam logic [31:0] B = 32'h1A10_0000;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] event_i = '0;
  logic       irq;

  ibex_apmu_counter_bank_if bus ();

  ibex_apmu_counter_bank #(
    .NUM_COUNTERS(4),
    .NUM_EVENTS  (8),
    .BASE_ADDR   (B)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .counter       (bus),
    .event_i       (event_i),
    .overflow_irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Issue one request at a negedge; the response is due one cycle later
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee);
    exp_t e;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = wd;
    e.cyc     = cyc;
    e.rdata   = er;
    e.err     = ee;
    exp_q.push_back(e);
    @(negedge clk);
    bus.req = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] er);
    xact(1'b0, a, 32'h0, er, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xact(1'b1, a, d, 32'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_ni) begin
      if (bus.rvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid_latency", cyc, e.cyc + 1);
          check("rdata", bus.rdata, e.rdata);
          check("err", {31'b0, bus.err}, {31'b0, e.err});
        end
      end else begin
        check("rdata_idle_zero", bus.rdata, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset and idle
    @(negedge clk);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    check("rst_err", {31'b0, bus.err}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    idle(2);
    rst_ni = 1'b1;
    rd(B + 32'h000, 32'h0);
    rd(B + 32'h004, 32'h0);
    rd(B + 32'h008, 32'h0);
    for (int i = 0; i < 4; i++) rd(B + 32'h040 + 32'(4 * i), 32'h0);
    rd(B + 32'h080, 32'h0);

    // Basic count: counter 1 on event 3, the rest on event 0
    wr(B + 32'h084, 32'h3);
    wr(B + 32'h000, 32'h1);
    for (int k = 0; k < 10; k++) begin
      event_i = 8'h08 | (((k % 2) == 1) ? 8'h01 : 8'hF0);
      @(negedge clk);
    end
    event_i = '0;
    wr(B + 32'h000, 32'h0);
    rd(B + 32'h040, 32'd5);
    rd(B + 32'h044, 32'd10);
    rd(B + 32'h048, 32'd5);
    rd(B + 32'h04C, 32'd5);
    rd(B + 32'h084, 32'h3);
    check("irq_before_wrap", {31'b0, irq}, 32'h0);

    // Wrap and interrupt on counter 2
    wr(B + 32'h048, 32'hFFFF_FFFE);
    wr(B + 32'h008, 32'h4);
    wr(B + 32'h000, 32'h1);
    event_i = 8'h01;
    idle(2);
    event_i = '0;
    check("irq_after_wrap", {31'b0, irq}, 32'h1);
    wr(B + 32'h000, 32'h0);
    rd(B + 32'h048, 32'h0);
    rd(B + 32'h004, 32'h4);
    rd(B + 32'h040, 32'd7);
    wr(B + 32'h004, 32'h4);
    check("irq_after_w1c", {31'b0, irq}, 32'h0);
    rd(B + 32'h004, 32'h0);

    // Priority: CNT write beats increment, CLR beats everything
    wr(B + 32'h000, 32'h1);
    event_i = 8'h01;
    wr(B + 32'h040, 32'h55);
    event_i = '0;
    rd(B + 32'h040, 32'h55);
    rd(B + 32'h04C, 32'd8);
    event_i = 8'hFF;
    wr(B + 32'h000, 32'h3);
    event_i = '0;
    for (int i = 0; i < 4; i++) rd(B + 32'h040 + 32'(4 * i), 32'h0);
    rd(B + 32'h000, 32'h1);
    rd(B + 32'h084, 32'h3);
    // Disabling write still counts its own cycle's event
    event_i = 8'h01;
    wr(B + 32'h000, 32'h0);
    event_i = '0;
    rd(B + 32'h040, 32'h1);
    rd(B + 32'h000, 32'h0);

    // Decode errors have no side effect and return zero data
    xact(1'b0, B + 32'h050, 32'h0, 32'h0, 1'b1);
    xact(1'b0, B + 32'h002, 32'h0, 32'h0, 1'b1);
    xact(1'b1, B + 32'h1000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xact(1'b1, B + 32'h042, 32'h0000_DEAD, 32'h0, 1'b1);
    xact(1'b1, B + 32'h054, 32'h7, 32'h0, 1'b1);
    xact(1'b0, B + 32'h00C, 32'h0, 32'h0, 1'b1);
    xact(1'b0, B + 32'h100, 32'h0, 32'h0, 1'b1);
    xact(1'b0, B - 32'h4, 32'h0, 32'h0, 1'b1);
    rd(B + 32'h000, 32'h0);
    rd(B + 32'h040, 32'h1);
    wr(B + 32'h008, 32'hFFFF_FFFF);
    rd(B + 32'h008, 32'hF);
    wr(B + 32'h080, 32'hFFFF_FFFF);
    rd(B + 32'h080, 32'h7);

    // Reset kills an in-flight read
    wr(B + 32'h044, 32'h1234);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = B + 32'h044;
    #2;
    rst_ni  = 1'b0;
    bus.req = 1'b0;
    @(negedge clk);
    check("midrst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    idle(2);
    rst_ni = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) rd(B + 32'h040 + 32'(4 * i), 32'h0);
    rd(B + 32'h000, 32'h0);
    rd(B + 32'h004, 32'h0);
    rd(B + 32'h008, 32'h0);
    rd(B + 32'h080, 32'h0);
    rd(B + 32'h084, 32'h0);
    check("irq_after_reset", {31'b0, irq}, 32'h0);

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
